line_ctrl: RTL and testbench

//  Control FSM for one direct-mapped cache line-array port. Latches a CPU (cmem) request and drives
//  the byte-merge datapath (offset/byte-enable/wdata into the 256-bit line). Sequences tag check,

---
 rtl/line_ctrl_if.sv | 47 ++++
 rtl/line_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_line_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_ctrl_if.sv
// Bundle of all non-clock signals between line_ctrl and its surroundings (CPU port, tag/data
// arrays, pmem port). master = surroundings, slave = line_ctrl.
interface line_ctrl_if;
    // Handshakes: cmem_read/cmem_write stay high until the one-cycle cmem_resp pulse;
    // pmem_read/pmem_write stay high until the one-cycle pmem_resp pulse.
    logic        cmem_read;
    logic        cmem_write;
    logic [4:0]  cmem_offset;
    logic [3:0]  cmem_byte_enable;
    logic [31:0] cmem_wdata;
    logic        cmem_resp;
    logic        cmem_err;
    logic        hit;
    logic        dirty;
    logic [4:0]  sel_offset;
    logic [3:0]  sel_byte_enable;
    logic [31:0] sel_wdata;
    logic        fill_sel;
    logic        data_we;
    logic        tag_we;
    logic        dirty_set;
    logic        dirty_clr;
    logic        victim_addr_sel;
    logic        pmem_read;
    logic        pmem_write;
    logic        pmem_resp;
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
    logic [31:0] perf_wbacks;
    logic [2:0]  dbg_state;

    modport master (
        output cmem_read, cmem_write, cmem_offset, cmem_byte_enable, cmem_wdata,
        output hit, dirty, pmem_resp,
        input  cmem_resp, cmem_err, sel_offset, sel_byte_enable, sel_wdata,
        input  fill_sel, data_we, tag_we, dirty_set, dirty_clr, victim_addr_sel,
        input  pmem_read, pmem_write, perf_hits, perf_misses, perf_wbacks, dbg_state
    );

    modport slave (
        input  cmem_read, cmem_write, cmem_offset, cmem_byte_enable, cmem_wdata,
        input  hit, dirty, pmem_resp,
        output cmem_resp, cmem_err, sel_offset, sel_byte_enable, sel_wdata,
        output fill_sel, data_we, tag_we, dirty_set, dirty_clr, victim_addr_sel,
        output pmem_read, pmem_write, perf_hits, perf_misses, perf_wbacks, dbg_state
    );
endinterface

// File: rtl/line_ctrl.sv
// Cache line-array port controller: tag check, dirty write-back, line fill, CPU response.
// Optional saturating performance counters when LINE_CTRL_PERF_EN is defined.
module line_ctrl #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    line_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        WBACK = 3'd2,
        FILL  = 3'd3,
        RESP  = 3'd4
    } state_e;

    localparam int TW = 10;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d;
    logic          wr_q, wr_d;
    logic [4:0]    off_q, off_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wd_q, wd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    logic       resp_c, err_c, fill_sel_c, data_we_c, tag_we_c;
    logic       dirty_set_c, dirty_clr_c, victim_c, pmem_read_c, pmem_write_c;
    logic [3:0] sel_be_c;

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        off_d        = off_q;
        be_d         = be_q;
        wd_d         = wd_q;
        timer_d      = timer_q;
        err_d        = err_q;
        resp_c       = 1'b0;
        err_c        = 1'b0;
        fill_sel_c   = 1'b0;
        data_we_c    = 1'b0;
        tag_we_c     = 1'b0;
        dirty_set_c  = 1'b0;
        dirty_clr_c  = 1'b0;
        victim_c     = 1'b0;
        pmem_read_c  = 1'b0;
        pmem_write_c = 1'b0;
        sel_be_c     = 4'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmem_read || bus.cmem_write) begin
                    // A simultaneous read+write is a write.
                    wr_d    = bus.cmem_write;
                    off_d   = bus.cmem_offset;
                    be_d    = bus.cmem_byte_enable;
                    wd_d    = bus.cmem_wdata;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                timer_d = '0;
                if (bus.hit) begin
                    if (wr_q) begin
                        data_we_c   = 1'b1;
                        dirty_set_c = 1'b1;
                        sel_be_c    = be_q;
                    end
                    state_d = RESP;
                end else if (bus.dirty) begin
                    state_d = WBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WBACK: begin
                pmem_write_c = 1'b1;
                victim_c     = 1'b1;
                if (bus.pmem_resp) begin
                    timer_d = '0;
                    state_d = FILL;
                end else if (timer_q == TLAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FILL: begin
                pmem_read_c = 1'b1;
                // A response arriving on the timeout cycle still completes the fill.
                if (bus.pmem_resp) begin
                    data_we_c   = 1'b1;
                    fill_sel_c  = 1'b1;
                    tag_we_c    = 1'b1;
                    dirty_clr_c = 1'b1;
                    state_d     = CHECK;
                end else if (timer_q == TLAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                resp_c  = 1'b1;
                err_c   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            off_q   <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            off_q   <= off_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmem_resp       = resp_c;
    assign bus.cmem_err        = err_c;
    assign bus.sel_offset      = off_q;
    assign bus.sel_byte_enable = sel_be_c;
    assign bus.sel_wdata       = wd_q;
    assign bus.fill_sel        = fill_sel_c;
    assign bus.data_we         = data_we_c;
    assign bus.tag_we          = tag_we_c;
    assign bus.dirty_set       = dirty_set_c;
    assign bus.dirty_clr       = dirty_clr_c;
    assign bus.victim_addr_sel = victim_c;
    assign bus.pmem_read       = pmem_read_c;
    assign bus.pmem_write      = pmem_write_c;
    assign bus.dbg_state       = state_q;

`ifdef LINE_CTRL_PERF_EN
    // rechk marks the CHECK that follows a fill so its hit is not counted twice.
    logic        rechk_q, rechk_d;
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;
    logic [31:0] wbacks_q, wbacks_d;

    always_comb begin
        rechk_d  = rechk_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        wbacks_d = wbacks_q;
        if (state_q == IDLE) rechk_d = 1'b0;
        if (state_q == FILL && bus.pmem_resp) rechk_d = 1'b1;
        if (state_q == CHECK) begin
            if (bus.hit) begin
                if (!rechk_q && hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
            end else if (misses_q != 32'hFFFF_FFFF) begin
                misses_d = misses_q + 32'd1;
            end
        end
        if (state_q == WBACK && bus.pmem_resp && wbacks_q != 32'hFFFF_FFFF)
            wbacks_d = wbacks_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rechk_q  <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
            wbacks_q <= '0;
        end else begin
            rechk_q  <= rechk_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            wbacks_q <= wbacks_d;
        end
    end

    assign bus.perf_hits   = hits_q;
    assign bus.perf_misses = misses_q;
    assign bus.perf_wbacks = wbacks_q;
`else
    assign bus.perf_hits   = '0;
    assign bus.perf_misses = '0;
    assign bus.perf_wbacks = '0;
`endif
endmodule

// File: tb/tb_line_ctrl.sv
// Directed bench for line_ctrl: each transaction is expanded into a per-cycle trace of
// inputs and expected outputs from the protocol rules, then replayed and compared.
module tb_line_ctrl;
    localparam int TO = 8;
    localparam int EW = 51;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    line_ctrl_if bus();
    line_ctrl #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic          rd, wr;
        logic [4:0]    off;
        logic [3:0]    be;
        logic [31:0]   wd;
        logic          hit, dirty, presp;
        logic [EW-1:0] exp;
    } cyc_t;

    cyc_t          cyc_q[$];
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    // Model state: last accepted offset/wdata and transaction-level counters.
    logic [4:0]  m_off;
    logic [31:0] m_wd;
    int          m_hits, m_misses, m_wbacks;

    function automatic logic [EW-1:0] ev(input bit pr, pw, vic, dwe, twe, fsel, dset, dclr,
                                         input bit resp, err, input logic [3:0] sbe,
                                         input logic [4:0] soff, input logic [31:0] swd);
        return {pr, pw, vic, dwe, twe, fsel, dset, dclr, resp, err, sbe, soff, swd};
    endfunction

    function automatic logic [EW-1:0] act();
        return {bus.pmem_read, bus.pmem_write, bus.victim_addr_sel, bus.data_we, bus.tag_we,
                bus.fill_sel, bus.dirty_set, bus.dirty_clr, bus.cmem_resp, bus.cmem_err,
                bus.sel_byte_enable, bus.sel_offset, bus.sel_wdata};
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, actual, expected);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("cycle_outputs", 64'(act()), 64'(e));
        end
    end

    task automatic drive_idle();
        bus.cmem_read        = 1'b0;
        bus.cmem_write       = 1'b0;
        bus.cmem_offset      = 5'd0;
        bus.cmem_byte_enable = 4'd0;
        bus.cmem_wdata       = 32'd0;
        bus.hit              = 1'b0;
        bus.dirty            = 1'b0;
        bus.pmem_resp        = 1'b0;
    endtask

    task automatic push(input logic rd, wr, input logic [4:0] off, input logic [3:0] be,
                        input logic [31:0] wd, input logic hit, dirty, presp,
                        input logic [EW-1:0] e);
        cyc_t c;
        c.rd = rd; c.wr = wr; c.off = off; c.be = be; c.wd = wd;
        c.hit = hit; c.dirty = dirty; c.presp = presp; c.exp = e;
        cyc_q.push_back(c);
    endtask

    task automatic run_q(output int resp_at);
        int k;
        cyc_t c;
        resp_at = -1;
        k = 0;
        while (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            @(posedge clk);
            #1;
            bus.cmem_read        = c.rd;
            bus.cmem_write       = c.wr;
            bus.cmem_offset      = c.off;
            bus.cmem_byte_enable = c.be;
            bus.cmem_wdata       = c.wd;
            bus.hit              = c.hit;
            bus.dirty            = c.dirty;
            bus.pmem_resp        = c.presp;
            exp_q.push_back(c.exp);
            @(negedge clk);
            if (bus.cmem_resp === 1'b1 && resp_at < 0) resp_at = k;
            k++;
        end
    endtask

    task automatic check_perf(input string name);
        int eh, em, ew;
`ifdef LINE_CTRL_PERF_EN
        eh = m_hits; em = m_misses; ew = m_wbacks;
`else
        eh = 0; em = 0; ew = 0;
`endif
        check({name, " perf_hits"},   64'(bus.perf_hits),   64'(eh));
        check({name, " perf_misses"}, 64'(bus.perf_misses), 64'(em));
        check({name, " perf_wbacks"}, 64'(bus.perf_wbacks), 64'(ew));
    endtask

    // wb_lat/fill_lat: pmem_resp arrives on that cycle of the strobe; 0 means never (timeout).
    task automatic txn(input string name, input logic rd, wr, input logic [4:0] off,
                       input logic [3:0] be, input logic [31:0] wd, input logic hit0, dirty0,
                       input int wb_lat, fill_lat, input int exp_resp);
        logic        w;
        logic [3:0]  wbe;
        logic [4:0]  go;
        logic [3:0]  gbe;
        logic [31:0] gwd;
        bit          err;
        bit          last;
        int          n;
        int          resp_at;
        w   = wr;
        wbe = wr ? be : 4'b0;
        go  = off ^ 5'h1f;
        gbe = ~be;
        gwd = ~wd;
        err = 1'b0;
        push(rd, wr, off, be, wd, 1'b0, dirty0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0, 4'b0, m_off, m_wd));
        m_off = off;
        m_wd  = wd;
        if (hit0) begin
            push(rd, wr, go, gbe, gwd, 1'b1, dirty0, 1'b0, ev(0,0,0,w,0,0,w,0,0,0, wbe, off, wd));
            m_hits++;
        end else begin
            push(rd, wr, go, gbe, gwd, 1'b0, dirty0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0, 4'b0, off, wd));
            m_misses++;
            if (dirty0) begin
                n = (wb_lat == 0) ? TO : wb_lat;
                for (int i = 0; i < n; i++) begin
                    last = (wb_lat != 0) && (i == n - 1);
                    push(rd, wr, go, gbe, gwd, 1'b0, dirty0, last, ev(0,1,1,0,0,0,0,0,0,0, 4'b0, off, wd));
                end
                if (wb_lat == 0) err = 1'b1;
                else m_wbacks++;
            end
            if (!err) begin
                n = (fill_lat == 0) ? TO : fill_lat;
                for (int i = 0; i < n; i++) begin
                    last = (fill_lat != 0) && (i == n - 1);
                    push(rd, wr, go, gbe, gwd, 1'b0, dirty0, last,
                         ev(1,0,0,last,last,last,0,last,0,0, 4'b0, off, wd));
                end
                if (fill_lat == 0) err = 1'b1;
                else push(rd, wr, go, gbe, gwd, 1'b1, dirty0, 1'b0, ev(0,0,0,w,0,0,w,0,0,0, wbe, off, wd));
            end
        end
        push(rd, wr, go, gbe, gwd, 1'b0, dirty0, 1'b0, ev(0,0,0,0,0,0,0,0,1,err, 4'b0, off, wd));
        push(1'b0, 1'b0, go, gbe, gwd, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0, 4'b0, off, wd));
        run_q(resp_at);
        check({name, " resp_cycle"}, 64'(resp_at), 64'(exp_resp));
        check_perf(name);
    endtask

    task automatic reset_during_fill();
        int dummy;
        push(1'b1, 1'b0, 5'd7, 4'hF, 32'h1111_2222, 1'b0, 1'b0, 1'b0,
             ev(0,0,0,0,0,0,0,0,0,0, 4'b0, m_off, m_wd));
        push(1'b1, 1'b0, 5'd7, 4'hF, 32'h1111_2222, 1'b0, 1'b0, 1'b0,
             ev(0,0,0,0,0,0,0,0,0,0, 4'b0, 5'd7, 32'h1111_2222));
        repeat (2) push(1'b1, 1'b0, 5'd7, 4'hF, 32'h1111_2222, 1'b0, 1'b0, 1'b0,
                        ev(1,0,0,0,0,0,0,0,0,0, 4'b0, 5'd7, 32'h1111_2222));
        run_q(dummy);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_fill pmem_read", 64'(bus.pmem_read), 64'd0);
        check("rst_fill state", 64'(bus.dbg_state), 64'd0);
        check("rst_fill sel_offset", 64'(bus.sel_offset), 64'd0);
        m_off = 5'd0; m_wd = 32'd0;
        m_hits = 0; m_misses = 0; m_wbacks = 0;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        check("rst_fill outputs", 64'(act()), 64'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        drive_idle();
        m_off = 5'd0; m_wd = 32'd0;
        m_hits = 0; m_misses = 0; m_wbacks = 0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'(act()), 64'd0);
        check("reset state", 64'(bus.dbg_state), 64'd0);
        check_perf("reset");
        reset_n = 1'b1;
        @(negedge clk);

        txn("read_hit",        1, 0, 5'd3,  4'h0,    32'h0000_0000, 1, 0, 0, 0, 2);
        txn("write_hit",       0, 1, 5'd5,  4'b0011, 32'hA5A5_1234, 1, 0, 0, 0, 2);
        txn("dirty_miss",      1, 0, 5'd8,  4'h0,    32'h0000_0000, 0, 1, 4, 4, 11);
        txn("clean_miss_wr",   0, 1, 5'd12, 4'b1100, 32'hDEAD_BEEF, 0, 0, 0, 3, 6);
        txn("fill_timeout",    1, 0, 5'd16, 4'h0,    32'h0000_0000, 0, 0, 0, 0, 10);
        txn("resp_on_timeout", 1, 0, 5'd20, 4'h0,    32'h0000_0000, 0, 0, 0, 8, 11);
        txn("wback_timeout",   0, 1, 5'd24, 4'b0101, 32'h0BAD_F00D, 0, 1, 0, 0, 10);
        txn("rd_wr_hit_off31", 1, 1, 5'd31, 4'b1111, 32'hCAFE_0031, 1, 0, 0, 0, 2);

        reset_during_fill();
        txn("post_reset_read", 1, 0, 5'd29, 4'h0,    32'h0000_0000, 1, 0, 0, 0, 2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
